// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch controller for the five-stage RISC-V pipeline. It reads
// the current pc from the pc register and drives npc back into it. It keeps
// at most one instruction-memory request outstanding. It delivers fetched
// words into the IF/ID slot, which ID may stall. A branch/jump redirect from
// EX flushes the slot and kills any fetch that is still in flight.
//
// Parameters
//   RESET_PC        value driven on npc while reset is high
//
// Ports
//   clk             sole clock, rising edge
//   reset           asynchronous, active-high reset
//   pc              current PC from the pc register
//   npc             next PC to the pc register (combinational)
//   imem_req        fetch request
//   imem_addr       word-aligned fetch address {pc[31:2],2'b00}
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response data valid (at least one cycle after gnt)
//   imem_rdata      instruction word returned by memory
//   redirect_valid  taken branch/jump from EX
//   redirect_pc     redirect target
//   stall           ID is not accepting the slot this cycle
//   if_id_valid     IF/ID slot holds an instruction
//   if_id_pc        PC of the slot instruction
//   if_id_instr     slot instruction
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  // REQ  : issuing a request for pc
  // WAIT : request accepted, waiting for the response
  // HOLD : a fetched word is parked in the hold buffer behind a stalled slot
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic        kill;
  logic        kill_nx;

  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        hold_load;

  logic        slot_load;
  logic [31:0] slot_load_pc;
  logic [31:0] slot_load_instr;
  logic        slot_valid_nx;

  logic        consume;
  logic        fetch_done;
  logic [31:0] pc_plus4;

  assign consume  = if_id_valid && !stall;
  assign pc_plus4 = pc + 32'd4;

  // A response that satisfies a live (not killed) request. The pc advances
  // on that edge whether the word goes to the slot or to the hold buffer.
  assign fetch_done = (state == S_WAIT) && imem_rvalid && !kill;

  assign imem_addr = {pc[31:2], 2'b00};

  // The request is gated by reset so that nothing is issued while the pc
  // register is being forced to RESET_PC. A redirect also suppresses it,
  // because the pc it would fetch is about to be replaced.
  always_comb begin
    imem_req = 1'b0;
    if (!reset && (state == S_REQ) && !redirect_valid) begin
      imem_req = 1'b1;
    end
  end

  // The next-PC mux. Priority is reset, then redirect, then sequential
  // advance on a completed fetch. Otherwise the pc is held.
  always_comb begin
    npc = pc;
    if (reset) begin
      npc = RESET_PC;
    end else if (redirect_valid) begin
      npc = redirect_pc;
    end else if (fetch_done) begin
      npc = pc_plus4;
    end
  end

  // Next-state, kill and slot/hold-buffer update decisions. A redirect
  // overrides every other event. It empties the slot. It drops the hold
  // buffer by leaving HOLD. It tags any request that is still in flight
  // with kill, so that the stale response is thrown away when it returns.
  always_comb begin
    state_nx        = state;
    kill_nx         = kill;
    hold_load       = 1'b0;
    slot_load       = 1'b0;
    slot_load_pc    = pc;
    slot_load_instr = imem_rdata;

    if (redirect_valid) begin
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            kill_nx  = 1'b1;
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          // Data arriving now answers the outstanding request, so there is
          // nothing left to kill. Without data, the request is still
          // pending and must be killed.
          if (imem_rvalid) begin
            kill_nx  = 1'b0;
            state_nx = S_REQ;
          end else begin
            kill_nx  = 1'b1;
            state_nx = S_WAIT;
          end
        end
        default: begin
          state_nx = S_REQ;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_nx  = 1'b0;
              state_nx = S_REQ;
            end else if (!if_id_valid || consume) begin
              slot_load = 1'b1;
              state_nx  = S_REQ;
            end else begin
              hold_load = 1'b1;
              state_nx  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            slot_load       = 1'b1;
            slot_load_pc    = hold_pc;
            slot_load_instr = hold_instr;
            state_nx        = S_REQ;
          end
        end
        default: begin
          state_nx = S_REQ;
        end
      endcase
    end
  end

  // Slot valid for the next cycle. A load fills the slot. A redirect
  // empties it. Otherwise the slot stays valid unless ID consumed it.
  always_comb begin
    slot_valid_nx = if_id_valid && !consume;
    if (redirect_valid) begin
      slot_valid_nx = 1'b0;
    end else if (slot_load) begin
      slot_valid_nx = 1'b1;
    end
  end

  // FSM state and kill flag. A response that is in flight during reset is
  // not tracked. Memory is expected to drop it on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_nx;
      kill  <= kill_nx;
    end
  end

  // Hold buffer. Its contents only matter while in HOLD, so it needs no
  // valid bit of its own. Leaving HOLD on a redirect drops it implicitly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_pc    <= 32'h0000_0000;
      hold_instr <= NOP_INSTR;
    end else if (hold_load) begin
      hold_pc    <= pc;
      hold_instr <= imem_rdata;
    end
  end

  // IF/ID slot. The pc and instr fields change only on a load. When the
  // slot is consumed or flushed they keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_INSTR;
    end else begin
      if_id_valid <= slot_valid_nx;
      if (slot_load && !redirect_valid) begin
        if_id_pc    <= slot_load_pc;
        if_id_instr <= slot_load_instr;
      end
    end
  end

endmodule
